tb_cycle_run_ctrl: RTL and testbench



---
 rtl/tb_cycle_run_ctrl_if.sv | 30 +++
 rtl/tb_cycle_run_ctrl.sv | 130 +++++++++++++
 tb/tb_tb_cycle_run_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tb_cycle_run_ctrl_if.sv
// Command/report/enable bundle between the RPC command shim and the run-cycle sequencer.
// The slave modport is the sequencer side; the master modport is the shim/bench side.
interface tb_cycle_run_ctrl_if #(
   parameter int CNT_WIDTH  = 32,
   parameter int TIME_WIDTH = 48
);
   logic                  req_valid;
   logic                  req_ready;
   logic [CNT_WIDTH-1:0]  req_count;
   logic                  req_mode;
   logic                  event_i;
   logic                  stop_req;
   logic                  clk_en;
   logic                  busy;
   logic                  done_valid;
   logic                  done_ready;
   logic [CNT_WIDTH-1:0]  done_count;
   logic [1:0]            done_reason;
   logic [TIME_WIDTH-1:0] sim_time;

   modport slave (
      input  req_valid, req_count, req_mode, event_i, stop_req, done_ready,
      output req_ready, clk_en, busy, done_valid, done_count, done_reason, sim_time
   );

   modport master (
      output req_valid, req_count, req_mode, event_i, stop_req, done_ready,
      input  req_ready, clk_en, busy, done_valid, done_count, done_reason, sim_time
   );
endinterface

// File: rtl/tb_cycle_run_ctrl.sv
// Run-cycle sequencer: runs N enabled cycles or until an event/stop, then reports the
// cycle count and cause. All outputs come straight from registers.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// RUN    | clk_en high, counting enabled cycles
// REPORT | done_valid high, holding count/reason until done_ready
module tb_cycle_run_ctrl #(
   parameter int CNT_WIDTH  = 32,
   parameter int TIME_WIDTH = 48
) (
   input  logic                 clock,
   input  logic                 reset,
   tb_cycle_run_ctrl_if.slave   ifc
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] REPORT = 2'd2;

   localparam logic [1:0] RSN_COUNT = 2'd0;
   localparam logic [1:0] RSN_EVENT = 2'd1;
   localparam logic [1:0] RSN_STOP  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};

   logic [1:0]            r_state;
   logic                  r_mode;
   logic                  r_limited;
   logic [CNT_WIDTH-1:0]  r_remaining;
   logic [CNT_WIDTH-1:0]  r_elapsed;
   logic                  r_req_ready;
   logic                  r_clk_en;
   logic                  r_busy;
   logic                  r_done_valid;
   logic [CNT_WIDTH-1:0]  r_done_count;
   logic [1:0]            r_done_reason;
   logic [TIME_WIDTH-1:0] r_sim_time;

   logic                  w_accept;
   logic                  w_stop;
   logic                  w_event;
   logic                  w_cnt_hit;
   logic                  w_exit;
   logic [1:0]            w_reason;
   logic [CNT_WIDTH-1:0]  w_elapsed_inc;

   assign w_accept      = ifc.req_valid && r_req_ready;
   assign w_stop        = ifc.stop_req;
   assign w_event       = r_mode && ifc.event_i;
   assign w_cnt_hit     = r_limited && (r_remaining == CNT_WIDTH'(1));
   assign w_exit        = w_stop || w_event || w_cnt_hit;
   assign w_reason      = w_stop ? RSN_STOP : (w_event ? RSN_EVENT : RSN_COUNT);
   // Saturate so an unlimited run never reports a wrapped (zero) count.
   assign w_elapsed_inc = (r_elapsed == CNT_ONES) ? CNT_ONES : r_elapsed + CNT_WIDTH'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_mode        <= 1'b0;
         r_limited     <= 1'b0;
         r_remaining   <= '0;
         r_elapsed     <= '0;
         r_req_ready   <= 1'b1;
         r_clk_en      <= 1'b0;
         r_busy        <= 1'b0;
         r_done_valid  <= 1'b0;
         r_done_count  <= '0;
         r_done_reason <= RSN_COUNT;
         r_sim_time    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mode      <= ifc.req_mode;
                  r_remaining <= ifc.req_count;
                  r_limited   <= (ifc.req_count != '0);
                  r_elapsed   <= '0;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if ((ifc.req_count == '0) && !ifc.req_mode) begin
                     r_state       <= REPORT;
                     r_done_valid  <= 1'b1;
                     r_done_count  <= '0;
                     r_done_reason <= RSN_COUNT;
                  end else begin
                     r_state  <= RUN;
                     r_clk_en <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_sim_time <= r_sim_time + TIME_WIDTH'(1);
               r_elapsed  <= w_elapsed_inc;
               if (r_limited) r_remaining <= r_remaining - CNT_WIDTH'(1);
               if (w_exit) begin
                  r_state       <= REPORT;
                  r_clk_en      <= 1'b0;
                  r_done_valid  <= 1'b1;
                  r_done_count  <= w_elapsed_inc;
                  r_done_reason <= w_reason;
               end
            end
            REPORT: begin
               if (ifc.done_ready) begin
                  r_state      <= IDLE;
                  r_done_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_req_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_clk_en    <= 1'b0;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ifc.req_ready   = r_req_ready;
   assign ifc.clk_en      = r_clk_en;
   assign ifc.busy        = r_busy;
   assign ifc.done_valid  = r_done_valid;
   assign ifc.done_count  = r_done_count;
   assign ifc.done_reason = r_done_reason;
   assign ifc.sim_time    = r_sim_time;

endmodule

// File: tb/tb_tb_cycle_run_ctrl.sv
// Directed bench for the run-cycle sequencer; expected values are hand-computed per vector.
module tb_tb_cycle_run_ctrl;

   localparam int CW = 32;
   localparam int TW = 48;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   en_cnt;
   int   lat;

   tb_cycle_run_ctrl_if #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) ifc ();

   tb_cycle_run_ctrl #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
      .clock (clock),
      .reset (reset),
      .ifc   (ifc.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one command; returns at the negedge of the first cycle after the accept edge.
   // Then walk the run, driving event_i/stop_req from given RUN cycles on, until done_valid.
   task automatic run_cmd(input int cnt, input bit mode, input int ev_cyc, input int stop_cyc,
                          input int max_cyc, output int en, output int latency);
      @(negedge clock);
      chk("req_ready_idle", ifc.req_ready, 1);
      ifc.req_valid = 1'b1;
      ifc.req_count = cnt;
      ifc.req_mode  = mode;
      @(negedge clock);
      ifc.req_valid = 1'b0;
      en = 0;
      latency = -1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         if (ifc.done_valid) begin
            latency = cyc;
            ifc.event_i  = 1'b0;
            ifc.stop_req = 1'b0;
            break;
         end
         if (ifc.clk_en) en++;
         ifc.event_i  = (ev_cyc != 0) && (cyc >= ev_cyc);
         ifc.stop_req = (stop_cyc != 0) && (cyc >= stop_cyc);
         @(negedge clock);
      end
      ifc.event_i  = 1'b0;
      ifc.stop_req = 1'b0;
      if (latency < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic ack();
      ifc.done_ready = 1'b1;
      @(negedge clock);
      ifc.done_ready = 1'b0;
      chk("ack_done_low", ifc.done_valid, 0);
      chk("ack_ready_high", ifc.req_ready, 1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      ifc.req_valid  = 1'b0;
      ifc.req_count  = '0;
      ifc.req_mode   = 1'b0;
      ifc.event_i    = 1'b0;
      ifc.stop_req   = 1'b0;
      ifc.done_ready = 1'b0;
      #1;
      chk("rst_ready", ifc.req_ready, 1);
      chk("rst_clk_en", ifc.clk_en, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done_valid", ifc.done_valid, 0);
      chk("rst_done_count", ifc.done_count, 0);
      chk("rst_reason", ifc.done_reason, 0);
      chk("rst_sim_time", ifc.sim_time, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Count 5: clk_en 5 cycles, done_valid the cycle after.
      run_cmd(5, 0, 0, 0, 20, en_cnt, lat);
      chk("c5_en", en_cnt, 5);
      chk("c5_lat", lat, 6);
      chk("c5_count", ifc.done_count, 5);
      chk("c5_reason", ifc.done_reason, 0);
      chk("c5_time", ifc.sim_time, 5);
      chk("c5_busy", ifc.busy, 1);
      ack();

      // Count 0: immediate report, no enable.
      run_cmd(0, 0, 0, 0, 20, en_cnt, lat);
      chk("c0_en", en_cnt, 0);
      chk("c0_lat", lat, 1);
      chk("c0_count", ifc.done_count, 0);
      chk("c0_reason", ifc.done_reason, 0);
      chk("c0_time", ifc.sim_time, 5);
      ack();

      // Event on RUN cycle 7 with timeout 100.
      run_cmd(100, 1, 7, 0, 200, en_cnt, lat);
      chk("ev_en", en_cnt, 7);
      chk("ev_count", ifc.done_count, 7);
      chk("ev_reason", ifc.done_reason, 1);
      chk("ev_time", ifc.sim_time, 12);
      ack();

      // Stop and event together on cycle 3, which is also the timeout cycle.
      run_cmd(3, 1, 3, 3, 20, en_cnt, lat);
      chk("st_en", en_cnt, 3);
      chk("st_count", ifc.done_count, 3);
      chk("st_reason", ifc.done_reason, 2);
      chk("st_time", ifc.sim_time, 15);

      // Hold the report 20 cycles with a competing request and stray event/stop.
      ifc.req_valid = 1'b1;
      ifc.req_count = 9;
      ifc.req_mode  = 1'b0;
      ifc.stop_req  = 1'b1;
      ifc.event_i   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("hold_valid", ifc.done_valid, 1);
         chk("hold_count", ifc.done_count, 3);
         chk("hold_reason", ifc.done_reason, 2);
         chk("hold_clk_en", ifc.clk_en, 0);
         chk("hold_ready", ifc.req_ready, 0);
      end
      ifc.req_valid = 1'b0;
      ifc.stop_req  = 1'b0;
      ifc.event_i   = 1'b0;
      ack();
      chk("hold_time", ifc.sim_time, 15);

      // Timeout in event mode: no event, count 4.
      run_cmd(4, 1, 0, 0, 20, en_cnt, lat);
      chk("to_en", en_cnt, 4);
      chk("to_count", ifc.done_count, 4);
      chk("to_reason", ifc.done_reason, 0);
      chk("to_time", ifc.sim_time, 19);
      ack();

      // Unlimited event mode, event on cycle 40.
      run_cmd(0, 1, 40, 0, 100, en_cnt, lat);
      chk("ul_en", en_cnt, 40);
      chk("ul_count", ifc.done_count, 40);
      chk("ul_reason", ifc.done_reason, 1);
      chk("ul_time", ifc.sim_time, 59);
      ack();

      // Reset during the 4th RUN cycle of a count-10 command.
      @(negedge clock);
      ifc.req_valid = 1'b1;
      ifc.req_count = 10;
      ifc.req_mode  = 1'b0;
      @(negedge clock);
      ifc.req_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("mr_clk_en_pre", ifc.clk_en, 1);
      reset = 1'b1;
      #1;
      chk("mr_clk_en", ifc.clk_en, 0);
      chk("mr_done_valid", ifc.done_valid, 0);
      chk("mr_sim_time", ifc.sim_time, 0);
      chk("mr_ready", ifc.req_ready, 1);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         chk("mr_no_report", ifc.done_valid, 0);
      end

      run_cmd(2, 0, 0, 0, 20, en_cnt, lat);
      chk("pr_en", en_cnt, 2);
      chk("pr_lat", lat, 3);
      chk("pr_count", ifc.done_count, 2);
      chk("pr_reason", ifc.done_reason, 0);
      chk("pr_time", ifc.sim_time, 2);
      ack();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
